rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//  Shares the register file's single write port between the in-order pipeline writeback and a
//  long-latency unit (mul/div) result stream. Buffers long-latency results in a small FIFO,
//  tracks destinations of outstanding long ops in a pending scoreboard, and raises decode stalls
//  on RAW/WAW hazards. Sits between the WB stage / long-latency unit and the RF write port.
// PARAMETERS
//  AW          5   register address width (32 registers; r0 hardwired zero)
//  DW          32  data width
//  DEPTH       2   result FIFO entries (power of two, >=2)
//  STARVE_LIM  4   cycles a FIFO head may wait before pipe_hold is raised
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  rst          in   1   asynchronous, active-high reset
//  wb_we        in   1   pipeline writeback request (never back-pressured)
//  wb_a3        in   AW  pipeline writeback register
//  wb_wd        in   DW  pipeline writeback data
//  lu_valid     in   1   long-latency result valid
//  lu_ready     out  1   FIFO can accept a result
//  lu_a3        in   AW  long-latency result register
//  lu_wd        in   DW  long-latency result data
//  lu_issue     in   1   long op issued this cycle; marks lu_issue_a3 pending
//  lu_issue_a3  in   AW  destination of issued long op
//  rd_a1,rd_a2  in   AW  decode source registers
//  rd_a3        in   AW  decode destination register (WAW check)
//  hazard_stall out  1   decode must stall
//  pipe_hold    out  1   pipeline must freeze writeback; wb_we must be 0 while high
//  rf_we        out  1   RF write enable
//  rf_a3        out  AW  RF write address
//  rf_wd        out  DW  RF write data
// BEHAVIOUR
//  - Reset (async): FIFO empty, pending[31:0]=0, age=0. While rst high: rf_we=0, lu_ready=0,
//    hazard_stall=0, pipe_hold=0. Reset mid-operation discards FIFO contents and all pending bits.
//  - Push: lu_valid&&lu_ready pushes {lu_a3,lu_wd}. lu_ready = !full (no bypass when full+pop).
//  - Port mux (combinational, same cycle): if wb_we&&wb_a3!=0 -> port = wb, FIFO holds;
//    else if FIFO non-empty -> port = FIFO head, pop at posedge; else rf_we=0.
//    wb_we with wb_a3==0 is a non-write; port goes to FIFO.
//  - FIFO head with a3==0: popped with rf_we=0.
//  - Latency: result accepted at cycle N reaches RF port at cycle N+1 at earliest (no bypass
//    into the port on an empty FIFO).
//  - Starvation: age counts consecutive cycles FIFO non-empty and not popped; clears on pop or
//    empty. pipe_hold = (age >= STARVE_LIM). Saturates at STARVE_LIM.
//  - Scoreboard: lu_issue && lu_issue_a3!=0 sets pending[a3]; popping head (a3!=0) clears
//    pending[head.a3]. Set and clear on the same register in one cycle: set wins.
//  - hazard_stall = pending[rd_a1] | pending[rd_a2] | pending[rd_a3] (index 0 never pending).
//    Combinational from registered pending; drops cycle after the RF write.
//  - FIFO/scoreboard pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
//  - Protocol violations (bench assertions): wb_we while pipe_hold; wb_a3 pending; lu_issue to
//    a pending register.
// STRUCTURE
//  - Shared package rf_pkg: AW, DW, REG_ZERO=5'd0, wb_req_t struct {a3,wd}.
//  - Sub-module rf_wb_fifo (DEPTH x (AW+DW), push/pop/full/empty/head). Arbiter, age counter
//    and scoreboard stay in this module.
// TESTING
//  1. Idle wb; push r5=0x00001234 at cycle N -> cycle N+1 rf_we=1, rf_a3=5, rf_wd=0x00001234;
//     pending[5] clear after that edge.
//  2. lu_issue r7, rd_a2=7 -> hazard_stall=1 every cycle until r7 result written, then 0.
//  3. wb_we=1 every cycle, push 2 results -> lu_ready=0 after 2nd push; RF sees only wb data;
//     pipe_hold=1 after 4 waiting cycles; wb_we=0 -> FIFO drains in 2 cycles, pipe_hold=0.
//  4. Same cycle: lu_issue r9 and FIFO head r9 written -> pending[9]=1, hazard_stall on rd_a1=9.
//  5. wb_we=1, wb_a3=0 with FIFO non-empty -> port carries FIFO head, rf_we=1, entry popped.
//  6. Assert rst with 2 FIFO entries and pending[3,4] set -> immediately rf_we=0, lu_ready=0;
//     after release FIFO empty, hazard_stall=0 for rd_a1=3.

Source files
------------

// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file write-port types and constants.
// Revision 1.0
`default_nettype none

package rf_pkg;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam logic [AW-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [AW-1:0] a3;
      logic [DW-1:0] wd;
   } wb_req_t;

endpackage

`default_nettype wire

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: small result FIFO holding long-latency writebacks until the RF port is free.
// Revision 1.0
`default_nettype none

module rf_wb_fifo
   import rf_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    i_push,
   input  wb_req_t i_data,
   input  logic    i_pop,
   output logic    o_full,
   output logic    o_empty,
   output wb_req_t o_head
);

   localparam int PW = $clog2(DEPTH);

   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [PW:0]   r_count;
   wb_req_t       r_mem [DEPTH];

   assign o_full  = (r_count == (PW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_head  = r_mem[r_rptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_wptr <= r_wptr + 1'b1;
         if (i_pop)  r_rptr <= r_rptr + 1'b1;
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wptr] <= i_data;
   end

endmodule

`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the RF write port between pipeline writeback and buffered
// long-latency results; tracks pending long-op destinations for decode hazard stalls.
// Revision 1.0
`default_nettype none

module rf_wb_arbiter
   import rf_pkg::*;
#(
   parameter int DEPTH      = 2,
   parameter int STARVE_LIM = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wb_we,
   input  logic [AW-1:0] wb_a3,
   input  logic [DW-1:0] wb_wd,
   input  logic          lu_valid,
   output logic          lu_ready,
   input  logic [AW-1:0] lu_a3,
   input  logic [DW-1:0] lu_wd,
   input  logic          lu_issue,
   input  logic [AW-1:0] lu_issue_a3,
   input  logic [AW-1:0] rd_a1,
   input  logic [AW-1:0] rd_a2,
   input  logic [AW-1:0] rd_a3,
   output logic          hazard_stall,
   output logic          pipe_hold,
   output logic          rf_we,
   output logic [AW-1:0] rf_a3,
   output logic [DW-1:0] rf_wd
);

   localparam int NREG = 1 << AW;
   localparam int AGW  = $clog2(STARVE_LIM + 1);

   logic            w_full;
   logic            w_empty;
   logic            w_push;
   logic            w_pop;
   logic            w_wb_sel;
   wb_req_t         w_head;
   wb_req_t         w_lu_req;
   logic [NREG-1:0] w_pending_nxt;
   logic [NREG-1:0] r_pending;
   logic [AGW-1:0]  r_age;

   assign w_lu_req = '{a3: lu_a3, wd: lu_wd};
   assign lu_ready = !rst && !w_full;
   assign w_push   = lu_valid && lu_ready;

   // Pipeline writeback owns the port; a write to r0 is treated as no request.
   assign w_wb_sel = wb_we && (wb_a3 != REG_ZERO);
   assign w_pop    = !w_wb_sel && !w_empty;

   assign rf_we = !rst && (w_wb_sel || (w_pop && (w_head.a3 != REG_ZERO)));
   assign rf_a3 = w_wb_sel ? wb_a3 : w_head.a3;
   assign rf_wd = w_wb_sel ? wb_wd : w_head.wd;

   rf_wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (w_lu_req),
      .i_pop   (w_pop),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_head  (w_head)
   );

   // Clear applied before set so a same-cycle issue to the retiring register stays pending.
   always_comb begin
      w_pending_nxt = r_pending;
      if (w_pop && (w_head.a3 != REG_ZERO)) w_pending_nxt[w_head.a3] = 1'b0;
      if (lu_issue && (lu_issue_a3 != REG_ZERO)) w_pending_nxt[lu_issue_a3] = 1'b1;
      w_pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pending <= '0;
         r_age     <= '0;
      end else begin
         r_pending <= w_pending_nxt;
         if (w_empty || w_pop)
            r_age <= '0;
         else if (r_age < AGW'(STARVE_LIM))
            r_age <= r_age + 1'b1;
      end
   end

   assign pipe_hold    = (r_age >= AGW'(STARVE_LIM));
   assign hazard_stall = r_pending[rd_a1] | r_pending[rd_a2] | r_pending[rd_a3];

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed stimulus with a queue scoreboard checking every RF port write.
// Revision 1.0
`default_nettype none

module tb_rf_wb_arbiter;
   import rf_pkg::*;

   logic          clk = 1'b0;
   logic          rst;
   logic          wb_we;
   logic [AW-1:0] wb_a3;
   logic [DW-1:0] wb_wd;
   logic          lu_valid;
   logic          lu_ready;
   logic [AW-1:0] lu_a3;
   logic [DW-1:0] lu_wd;
   logic          lu_issue;
   logic [AW-1:0] lu_issue_a3;
   logic [AW-1:0] rd_a1;
   logic [AW-1:0] rd_a2;
   logic [AW-1:0] rd_a3;
   logic          hazard_stall;
   logic          pipe_hold;
   logic          rf_we;
   logic [AW-1:0] rf_a3;
   logic [DW-1:0] rf_wd;

   int n_cmp = 0;
   int n_bad = 0;
   logic [AW+DW-1:0] q_wb[$];
   logic [AW+DW-1:0] q_lu[$];

   rf_wb_arbiter #(
      .DEPTH      (2),
      .STARVE_LIM (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .wb_we        (wb_we),
      .wb_a3        (wb_a3),
      .wb_wd        (wb_wd),
      .lu_valid     (lu_valid),
      .lu_ready     (lu_ready),
      .lu_a3        (lu_a3),
      .lu_wd        (lu_wd),
      .lu_issue     (lu_issue),
      .lu_issue_a3  (lu_issue_a3),
      .rd_a1        (rd_a1),
      .rd_a2        (rd_a2),
      .rd_a3        (rd_a3),
      .hazard_stall (hazard_stall),
      .pipe_hold    (pipe_hold),
      .rf_we        (rf_we),
      .rf_a3        (rf_a3),
      .rf_wd        (rf_wd)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic push_lu(input logic [AW-1:0] a3, input logic [DW-1:0] wd, input bit expect_write);
      lu_valid = 1'b1;
      lu_a3    = a3;
      lu_wd    = wd;
      if (expect_write) q_lu.push_back({a3, wd});
   endtask

   task automatic drive_wb(input logic [AW-1:0] a3, input logic [DW-1:0] wd);
      wb_we = 1'b1;
      wb_a3 = a3;
      wb_wd = wd;
      q_wb.push_back({a3, wd});
   endtask

   // Monitor: every RF write is matched against the queue of its expected source.
   always @(negedge clk) begin
      if (!rst && rf_we) begin
         if (wb_we && (wb_a3 != REG_ZERO)) begin
            if (q_wb.size() == 0) chk("wb_unexpected", 64'({rf_a3, rf_wd}), 64'd0);
            else chk("wb_write", 64'({rf_a3, rf_wd}), 64'(q_wb.pop_front()));
         end else begin
            if (q_lu.size() == 0) chk("lu_unexpected", 64'({rf_a3, rf_wd}), 64'd0);
            else chk("lu_write", 64'({rf_a3, rf_wd}), 64'(q_lu.pop_front()));
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         assert (!(wb_we && pipe_hold)) else $error("protocol: wb_we while pipe_hold");
         assert (!(wb_we && (wb_a3 != REG_ZERO) && dut.r_pending[wb_a3]))
            else $error("protocol: wb_a3 pending");
         assert (!(lu_issue && dut.r_pending[lu_issue_a3]))
            else $error("protocol: lu_issue to pending register");
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; wb_we = 1'b1; wb_a3 = 5'd3; wb_wd = 32'hFFFF_FFFF;
      lu_valid = 1'b0; lu_a3 = '0; lu_wd = '0; lu_issue = 1'b0; lu_issue_a3 = '0;
      rd_a1 = '0; rd_a2 = '0; rd_a3 = '0;
      at_neg();
      chk("reset_rf_we", 64'(rf_we), 64'd0);
      chk("reset_lu_ready", 64'(lu_ready), 64'd0);
      chk("reset_hazard", 64'(hazard_stall), 64'd0);
      chk("reset_pipe_hold", 64'(pipe_hold), 64'd0);
      tick();
      rst = 1'b0; wb_we = 1'b0; wb_a3 = '0;

      // 1: issue r5, result pushed next cycle, written one cycle after push
      tick(); lu_issue = 1'b1; lu_issue_a3 = 5'd5; rd_a1 = 5'd5;
      at_neg(); chk("t1_hazard_pre", 64'(hazard_stall), 64'd0);
      tick(); lu_issue = 1'b0; push_lu(5'd5, 32'h0000_1234, 1'b1);
      at_neg();
      chk("t1_hazard_set", 64'(hazard_stall), 64'd1);
      chk("t1_no_bypass", 64'(rf_we), 64'd0);
      chk("t1_lu_ready", 64'(lu_ready), 64'd1);
      tick(); lu_valid = 1'b0;
      at_neg(); chk("t1_hazard_write_cycle", 64'(hazard_stall), 64'd1);
      tick();
      at_neg(); chk("t1_hazard_clear", 64'(hazard_stall), 64'd0);
      rd_a1 = '0;

      // 2: RAW on rd_a2 held until the r7 result is written
      tick(); lu_issue = 1'b1; lu_issue_a3 = 5'd7; rd_a2 = 5'd7;
      for (int i = 0; i < 3; i++) begin
         tick(); lu_issue = 1'b0;
         at_neg(); chk("t2_hazard_wait", 64'(hazard_stall), 64'd1);
      end
      tick(); push_lu(5'd7, 32'hBEEF_0007, 1'b1);
      at_neg(); chk("t2_hazard_push", 64'(hazard_stall), 64'd1);
      tick(); lu_valid = 1'b0;
      at_neg(); chk("t2_hazard_write", 64'(hazard_stall), 64'd1);
      tick();
      at_neg(); chk("t2_hazard_clear", 64'(hazard_stall), 64'd0);
      rd_a2 = '0;

      // 3: continuous wb starves the FIFO until pipe_hold
      for (int i = 0; i < 5; i++) begin
         tick();
         drive_wb(5'(10 + i), 32'(32'hA0 + i));
         if (i < 2) push_lu(5'(12 + i), 32'(32'hC0 + i), 1'b1);
         else lu_valid = 1'b0;
         at_neg();
         if (i == 2) chk("t3_full_ready", 64'(lu_ready), 64'd0);
         if (i >= 2) chk("t3_no_hold_yet", 64'(pipe_hold), 64'd0);
      end
      tick();
      chk("t3_pipe_hold", 64'(pipe_hold), 64'd1);
      wb_we = 1'b0;
      at_neg();
      tick();
      at_neg();
      chk("t3_hold_released", 64'(pipe_hold), 64'd0);
      chk("t3_ready_again", 64'(lu_ready), 64'd1);
      tick();
      at_neg(); chk("t3_drained", 64'(rf_we), 64'd0);

      // 4: issue r9 in the cycle its previous result retires; set wins
      tick(); push_lu(5'd9, 32'h0909_0909, 1'b1);
      tick(); lu_valid = 1'b0; lu_issue = 1'b1; lu_issue_a3 = 5'd9; rd_a1 = 5'd9;
      at_neg(); chk("t4_hazard_before", 64'(hazard_stall), 64'd0);
      tick(); lu_issue = 1'b0;
      at_neg(); chk("t4_set_wins", 64'(hazard_stall), 64'd1);
      tick(); push_lu(5'd9, 32'h9999_0000, 1'b1);
      at_neg(); chk("t4_still_pending", 64'(hazard_stall), 64'd1);
      tick(); lu_valid = 1'b0;
      at_neg();
      tick();
      at_neg(); chk("t4_cleared", 64'(hazard_stall), 64'd0);
      rd_a1 = '0;

      // 5: wb to r0 yields the port; FIFO entry to r0 is dropped
      tick(); push_lu(5'd20, 32'h5555_AAAA, 1'b1);
      tick(); lu_valid = 1'b0; wb_we = 1'b1; wb_a3 = 5'd0; wb_wd = 32'hDEAD_DEAD;
      at_neg(); chk("t5_r0_wb_yields", 64'(rf_we), 64'd1);
      tick(); wb_we = 1'b0;
      at_neg(); chk("t5_popped", 64'(rf_we), 64'd0);
      tick(); push_lu(5'd0, 32'h1111_1111, 1'b0);
      tick(); push_lu(5'd21, 32'h2121_2121, 1'b1);
      at_neg(); chk("t5_r0_head_no_write", 64'(rf_we), 64'd0);
      tick(); lu_valid = 1'b0;
      at_neg();

      // 6: reset with a full FIFO and pending r3/r4
      tick(); lu_issue = 1'b1; lu_issue_a3 = 5'd3;
      drive_wb(5'd15, 32'h0F0F_0F0F); push_lu(5'd22, 32'h2222_2222, 1'b0);
      tick(); lu_issue_a3 = 5'd4; rd_a1 = 5'd3;
      drive_wb(5'd16, 32'h1616_1616); push_lu(5'd23, 32'h2323_2323, 1'b0);
      at_neg(); chk("t6_pending_r3", 64'(hazard_stall), 64'd1);
      tick(); lu_issue = 1'b0; lu_valid = 1'b0; wb_a3 = 5'd17; wb_wd = 32'h1717_1717;
      rst = 1'b1;
      #1;
      chk("t6_rst_rf_we", 64'(rf_we), 64'd0);
      chk("t6_rst_lu_ready", 64'(lu_ready), 64'd0);
      tick(); rst = 1'b0; wb_we = 1'b0; rd_a1 = 5'd3; rd_a2 = 5'd4;
      at_neg();
      chk("t6_hazard_gone", 64'(hazard_stall), 64'd0);
      chk("t6_ready_after", 64'(lu_ready), 64'd1);
      chk("t6_fifo_empty", 64'(rf_we), 64'd0);
      tick();
      at_neg(); chk("t6_no_stale_write", 64'(rf_we), 64'd0);

      chk("wb_queue_drained", 64'(q_wb.size()), 64'd0);
      chk("lu_queue_drained", 64'(q_lu.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
